// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: read-mode encodings and the
// wrap-around pointer increment used by every FIFO variant.
package fifo_pkg;

    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Depth need not be a power of two, so the wrap is an explicit compare.
    function automatic int unsigned ptrIncr(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Depth x DataSize storage array with one synchronous write port and one
// asynchronous read port; contents are never reset.
module fifo_ram #(
    parameter int DataSize  = 8,
    parameter int Depth     = 16,
    parameter int AddrWidth = $clog2(Depth)
) (
    input  logic                 clk_i,
    input  logic                 wrEn_i,
    input  logic [AddrWidth-1:0] wrAddr_i,
    input  logic [DataSize-1:0]  wrData_i,
    input  logic [AddrWidth-1:0] rdAddr_i,
    output logic [DataSize-1:0]  rdData_o
);

    logic [DataSize-1:0] mem_q [Depth];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) begin
            mem_q[wrAddr_i] <= wrData_i;
        end
    end

    assign rdData_o = mem_q[rdAddr_i];

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO with arbitrary depth, standard or first-word-fall-through
// read mode, occupancy count, almost flags and sticky error flags.
module synchronous_fifo
    import fifo_pkg::*;
#(
    parameter int DataSize          = 8,
    parameter int Depth             = 16,
    parameter int AlmostFullThresh  = Depth - 2,
    parameter int AlmostEmptyThresh = 2,
    parameter int Mode              = FIFO_MODE_STD,
    parameter int CntWidth          = $clog2(Depth + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                Push,
    input  logic [DataSize-1:0] DataIn,
    input  logic                Pop,
    output logic [DataSize-1:0] DataOut,
    output logic                DataValid,
    output logic                full,
    output logic                empty,
    output logic                AlmostFull,
    output logic                AlmostEmpty,
    output logic [CntWidth-1:0] Count,
    output logic                Overflow,
    output logic                Underflow,
    input  logic                ClearErr
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);
    localparam logic [CntWidth-1:0] AfThresh = CntWidth'(AlmostFullThresh);
    localparam logic [CntWidth-1:0] AeThresh = CntWidth'(AlmostEmptyThresh);

    logic [PtrWidth-1:0] wrPtr_q, wrPtr_d;
    logic [PtrWidth-1:0] rdPtr_q, rdPtr_d;
    logic [CntWidth-1:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [DataSize-1:0] dataOut_q, dataOut_d;
    logic                dataValid_q, dataValid_d;
    logic [DataSize-1:0] ramRdData;
    logic                isFull, isEmpty, pushAcc, popAcc;

    // Flags come only from the count register, never from Push/Pop.
    assign isFull  = (count_q == DepthCnt);
    assign isEmpty = (count_q == '0);
    assign popAcc  = Pop && !isEmpty;
    assign pushAcc = Push && (!isFull || popAcc);

    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        dataOut_d   = dataOut_q;
        dataValid_d = popAcc;

        if (pushAcc) begin
            wrPtr_d = PtrWidth'(ptrIncr(32'(wrPtr_q), Depth));
        end
        if (popAcc) begin
            rdPtr_d   = PtrWidth'(ptrIncr(32'(rdPtr_q), Depth));
            dataOut_d = ramRdData;
        end

        case ({pushAcc, popAcc})
            2'b10:   count_d = count_q + CntWidth'(1);
            2'b01:   count_d = count_q - CntWidth'(1);
            default: count_d = count_q;
        endcase

        // A new error in the same cycle as ClearErr keeps the flag set.
        if (Push && !pushAcc) begin
            overflow_d = 1'b1;
        end else if (ClearErr) begin
            overflow_d = 1'b0;
        end
        if (Pop && isEmpty) begin
            underflow_d = 1'b1;
        end else if (ClearErr) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            dataOut_q   <= '0;
            dataValid_q <= 1'b0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            dataOut_q   <= dataOut_d;
            dataValid_q <= dataValid_d;
        end
    end

    fifo_ram #(
        .DataSize (DataSize),
        .Depth    (Depth)
    ) u_ram (
        .clk_i    (clk),
        .wrEn_i   (pushAcc && !reset),
        .wrAddr_i (wrPtr_q),
        .wrData_i (DataIn),
        .rdAddr_i (rdPtr_q),
        .rdData_o (ramRdData)
    );

    // FWFT shows the head entry directly; it reads as zero while empty.
    generate
        if (Mode == FIFO_MODE_FWFT) begin : g_fwft
            assign DataOut   = isEmpty ? '0 : ramRdData;
            assign DataValid = !isEmpty;
        end else begin : g_std
            assign DataOut   = dataOut_q;
            assign DataValid = dataValid_q;
        end
    endgenerate

    assign full        = isFull;
    assign empty       = isEmpty;
    assign AlmostFull  = (count_q >= AfThresh);
    assign AlmostEmpty = (count_q <= AeThresh);
    assign Count       = count_q;
    assign Overflow    = overflow_q;
    assign Underflow   = underflow_q;

endmodule

// File: doc/synchronous_fifo.md
# synchronous_fifo

Parametrised single-clock FIFO, successor to the dual-clock FIFO for paths where producer and consumer share a clock domain. Adds arbitrary (non power-of-two) depth, selectable standard or first-word-fall-through read mode, occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. Used as the generic buffering primitive between pipeline stages and as the back end of channel adapters.

## Interface
- DataSize, 8, data word width in bits (≥1)
- Depth, 16, number of storage entries (≥2; any integer, no power-of-two requirement)
- AlmostFullThresh, Depth-2, AlmostFull asserts when Count ≥ this value (1..Depth)
- AlmostEmptyThresh, 2, AlmostEmpty asserts when Count ≤ this value (0..Depth-1)
- Mode, 0, read mode: 0 = standard (registered, 1-cycle read latency), 1 = FWFT
- CntWidth, $clog2(Depth+1), width of Count (derived; not overridden)

Ports:
- clk  input  1  sole clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- Push  input  1  write request
- DataIn  input  DataSize  write data, sampled on accepted Push
- Pop  input  1  read request
- DataOut  output  DataSize  read data
- DataValid  output  1  DataOut holds valid data (meaning is mode-dependent)
- full  output  1  Count == Depth
- empty  output  1  Count == 0
- AlmostFull  output  1  Count ≥ AlmostFullThresh
- AlmostEmpty  output  1  Count ≤ AlmostEmptyThresh
- Count  output  CntWidth  current occupancy, 0..Depth
- Overflow  output  1  sticky: a Push was rejected
- Underflow  output  1  sticky: a Pop was rejected
- ClearErr  input  1  clears Overflow and Underflow

## Operation
- Pop accepted (PopAcc) = Pop && !empty.
- Push accepted (PushAcc) = Push && (!full || PopAcc). A push while full is accepted only alongside an accepted pop in the same cycle.
- Storage: write pointer and read pointer, each 0..Depth-1, incremented on PushAcc / PopAcc respectively. Each wraps from Depth-1 to 0 by explicit compare, not by bit overflow.
- Count: +1 on PushAcc only, −1 on PopAcc only, unchanged when both or neither.
- full, empty, AlmostFull and AlmostEmpty are decoded from the Count register (no combinational path from Push/Pop).
- Mode 0 (standard):
  - On PopAcc, DataOut is loaded with the head entry at the next edge, and DataValid is high for exactly that one cycle.
  - Otherwise DataOut holds its value and DataValid is 0.
- Mode 1 (FWFT):
  - DataOut = entry at read pointer; DataValid = !empty.
  - Pop consumes the displayed word; the next word (if any) is shown in the following cycle.
- Overflow is set when Push && !PushAcc. Underflow is set when Pop && empty.
  - Both are cleared by ClearErr.
  - If a set condition and ClearErr occur in the same cycle, set wins.
- Push and Pop while empty: push accepted, pop rejected (Underflow set), Count becomes 1.
- Push and Pop while full: both accepted, Count stays Depth, full stays 1.
- Reset mid-operation discards all contents.
  - Pointers and Count go to 0; memory contents are not cleared and are unobservable.
  - Push/Pop in the reset cycle are ignored; no error flags are set.

## Timing
- Reset values (one edge with reset high):
  - Count=0, empty=1, full=0, AlmostEmpty=1, AlmostFull=0.
  - DataOut=0, DataValid=0, Overflow=0, Underflow=0.
- Write-to-flag latency: Count, full, empty and almost flags update at the edge that accepts the operation.
- Write-to-read latency:
  - FWFT: a word pushed into an empty FIFO at edge N is on DataOut with DataValid=1 after edge N.
  - Standard: the earliest Pop is in cycle N+1, with data after edge N+2.
- Standard-mode read latency: 1 cycle from accepted Pop to DataValid.
- Back-to-back Push and Pop at full rate are sustained indefinitely in both modes at any occupancy 1..Depth-1.

## Structure
- Shared package fifo_pkg holds:
  - mode constants FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1;
  - a pointer-increment-with-wrap function parametrised by Depth, reused by future FIFO variants.
- One sub-module: fifo_ram.
  - Depth × DataSize storage, one synchronous write port and one asynchronous read port, no reset.
  - The top level owns pointers, Count, flags and the output register.

## Test plan
- Reset and fill (Depth=5, Mode=0, DataSize=8):
  - Release reset and check empty=1, Count=0.
  - Push 0x11..0x55 over 5 cycles → Count=5, full=1, AlmostFull=1 from Count=3.
  - 6th Push → Overflow=1, Count stays 5.
- Drain with wrap-around (same configuration):
  - Pop 5 times → DataOut 0x11..0x55, each with a 1-cycle DataValid one cycle after its Pop.
  - Then push/pop 12 more words → order preserved across pointer wrap at 4→0.
  - Extra Pop when empty → Underflow=1.
- FWFT (Mode=1, Depth=4):
  - Push 0xA5 → DataOut=0xA5 and DataValid=1 the next cycle, before any Pop.
  - Pop → empty=1, DataValid=0.
- Simultaneous events:
  - At full: Push 0x77 + Pop together → Count stays 4, 0x77 emerges after the three older words.
  - At empty: Push + Pop together → Count=1, Underflow=1.
- Error clear and reset mid-operation:
  - ClearErr in the same cycle as a new overflow → Overflow remains 1; ClearErr alone → 0.
  - Assert reset with Count=3 → all outputs at their reset values after one edge; a subsequent Push/Pop returns the new word, not stale data.
